johnson_step_controller: RTL and testbench



---
 rtl/johnson_step_controller_pkg.sv | 18 +
 rtl/johnson_step_controller_if.sv | 28 ++
 rtl/johnson_shift_reg.sv | 29 ++
 rtl/johnson_step_controller.sv | 111 +++++++++++
 tb/tb_johnson_step_controller.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_step_controller_pkg.sv
// Shared types and constants for the Johnson step controller and its
// shift-register sub-block.
package johnson_step_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Phase index must cover 0..2*width-1.
  function automatic int phase_w(input int width);
    return (width < 1) ? 1 : $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_step_controller_if.sv
// Command handshake between a control master and the Johnson step controller.
interface johnson_step_controller_if #(
  parameter int CNT_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic             abort;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  abort,
    output cmd_ready
  );

endinterface

// File: rtl/johnson_shift_reg.sv
// WIDTH-bit Johnson register; advances one code per enabled edge in the
// requested direction. Reverse is the exact inverse of forward.
module johnson_shift_reg
  import johnson_step_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] fwd_next;
  logic [WIDTH-1:0] rev_next;

  assign fwd_next = {~out[0], out[WIDTH-1:1]};
  assign rev_next = {out[WIDTH-2:0], ~out[WIDTH-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (en) begin
      out <= (dir == DIR_REV) ? rev_next : fwd_next;
    end
  end

endmodule

// File: rtl/johnson_step_controller.sv
// Runs a Johnson counter a commanded number of steps forward or reverse
// under a valid/ready handshake, with abort and done/aborted status pulses.
module johnson_step_controller
  import johnson_step_controller_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int PHASE_W = phase_w(WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  johnson_step_controller_if.slave    cmd,
  output logic [WIDTH-1:0]            out,
  output logic [PHASE_W-1:0]          phase,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_d, aborted_d;
  logic             accept;
  logic             step_en;
  int unsigned      ones;

  assign cmd.cmd_ready = (state_q == IDLE) && !cmd.abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    step_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = cmd.cmd_steps;
            dir_d   = cmd.cmd_dir;
          end
        end
      end
      RUN: begin
        // Abort wins over the pending step: the code freezes where it is.
        if (cmd.abort) begin
          state_d   = IDLE;
          rem_d     = '0;
          aborted_d = 1'b1;
        end else begin
          step_en = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_FWD;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done    <= done_d;
      aborted <= aborted_d;
    end
  end

  johnson_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .en   (step_en),
    .dir  (dir_q),
    .out  (out)
  );

  // MSB set: ones fill from the top, phase equals the count of ones.
  // MSB clear: ones drain toward the bottom, phase counts back from 2*WIDTH.
  always_comb begin
    ones = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (out[i]) ones++;
    end
    if (out[WIDTH-1]) begin
      phase = PHASE_W'(ones);
    end else if (ones == 0) begin
      phase = '0;
    end else begin
      phase = PHASE_W'(2 * WIDTH - ones);
    end
  end

endmodule

// File: tb/tb_johnson_step_controller.sv
// Self-checking bench for johnson_step_controller: directed scenarios plus
// randomized commands checked against a position-based reference model.
module tb_johnson_step_controller;

  localparam int W = 4;
  localparam int N = 2 * W;

  logic         clk;
  logic         reset;
  logic [W-1:0] out;
  logic [2:0]   phase;
  logic         busy, done, aborted;

  int cmp;
  int errs;
  int pos;

  johnson_step_controller_if #(.CNT_W(8)) cif ();

  johnson_step_controller #(
    .WIDTH(W),
    .CNT_W(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cif),
    .out    (out),
    .phase  (phase),
    .busy   (busy),
    .done   (done),
    .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson code for sequence position p: ones fill from the MSB for p<=W,
  // then drain from the MSB leaving 2W-p ones at the bottom.
  function automatic logic [W-1:0] code_of(input int p);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      if (p <= W) c[i] = ((W - 1 - i) < p);
      else        c[i] = (i < (N - p));
    end
    return c;
  endfunction

  task automatic issue(input int steps, input logic dir);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = 8'(steps);
    cif.cmd_dir   = dir;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    cif.cmd_steps = 8'($urandom);
    cif.cmd_dir   = 1'($urandom);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cif.cmd_valid = 1'b0; cif.cmd_steps = '0; cif.cmd_dir = 1'b0; cif.abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pos = 0;
    @(negedge clk);
    cmp++; if (out !== 4'b0000) begin errs++; $display("FAIL reset_out: got %b want 0000", out); end
    cmp++; if (phase !== 3'd0) begin errs++; $display("FAIL reset_phase: got %0d want 0", phase); end
    cmp++; if (cif.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", cif.cmd_ready); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp++; if (done !== 1'b0 || aborted !== 1'b0) begin errs++; $display("FAIL reset_pulses: got done=%b aborted=%b want 0 0", done, aborted); end
  endtask

  task automatic test_fwd3();
    logic [W-1:0] exp_code [3];
    int           exp_ph [3];
    exp_code = '{4'b1000, 4'b1100, 4'b1110};
    exp_ph   = '{1, 2, 3};
    issue(3, 1'b0);
    @(negedge clk);
    cmp++; if (busy !== 1'b1 || out !== 4'b0000) begin errs++; $display("FAIL fwd3_accept: got busy=%b out=%b want 1 0000", busy, out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp++; if (out !== exp_code[k]) begin errs++; $display("FAIL fwd3_out[%0d]: got %b want %b", k, out, exp_code[k]); end
      cmp++; if (phase !== 3'(exp_ph[k])) begin errs++; $display("FAIL fwd3_phase[%0d]: got %0d want %0d", k, phase, exp_ph[k]); end
      cmp++; if (busy !== (k < 2) || done !== (k == 2)) begin errs++; $display("FAIL fwd3_status[%0d]: got busy=%b done=%b want %b %b", k, busy, done, k < 2, k == 2); end
    end
    @(negedge clk);
    cmp++; if (done !== 1'b0 || cif.cmd_ready !== 1'b1) begin errs++; $display("FAIL fwd3_after: got done=%b ready=%b want 0 1", done, cif.cmd_ready); end
    pos = 3;
  endtask

  task automatic test_rev5();
    logic [W-1:0] exp_code [5];
    int           exp_ph [5];
    exp_code = '{4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011};
    exp_ph   = '{2, 1, 0, 7, 6};
    issue(5, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp++; if (out !== exp_code[k]) begin errs++; $display("FAIL rev5_out[%0d]: got %b want %b", k, out, exp_code[k]); end
      cmp++; if (phase !== 3'(exp_ph[k])) begin errs++; $display("FAIL rev5_phase[%0d]: got %0d want %0d", k, phase, exp_ph[k]); end
      cmp++; if (done !== (k == 4)) begin errs++; $display("FAIL rev5_done[%0d]: got %b want %b", k, done, k == 4); end
    end
    @(negedge clk);
    cmp++; if (done !== 1'b0) begin errs++; $display("FAIL rev5_single_done: got %b want 0", done); end
    pos = 6;
  endtask

  task automatic test_zero();
    issue(0, 1'b1);
    @(negedge clk);
    cmp++; if (done !== 1'b1 || busy !== 1'b0 || out !== 4'b0011) begin errs++; $display("FAIL zero_accept: got done=%b busy=%b out=%b want 1 0 0011", done, busy, out); end
    @(negedge clk);
    cmp++; if (done !== 1'b0 || busy !== 1'b0 || out !== 4'b0011) begin errs++; $display("FAIL zero_after: got done=%b busy=%b out=%b want 0 0 0011", done, busy, out); end
  endtask

  task automatic test_abort_wrap();
    pulse_reset();
    // Abort in IDLE masks ready and blocks a simultaneous command.
    cif.abort = 1'b1; cif.cmd_valid = 1'b1; cif.cmd_steps = 8'd5; cif.cmd_dir = 1'b0;
    #1;
    cmp++; if (cif.cmd_ready !== 1'b0) begin errs++; $display("FAIL idle_abort_ready: got %b want 0", cif.cmd_ready); end
    @(negedge clk);
    cmp++; if (busy !== 1'b0 || done !== 1'b0 || out !== 4'b0000) begin errs++; $display("FAIL idle_abort_prio: got busy=%b done=%b out=%b want 0 0 0000", busy, done, out); end
    cif.abort = 1'b0; cif.cmd_valid = 1'b0;
    issue(20, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cmp++; if (out !== code_of(k)) begin errs++; $display("FAIL abort_step[%0d]: got %b want %b", k, out, code_of(k)); end
    end
    cif.abort = 1'b1;
    @(negedge clk);
    cmp++; if (aborted !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL abort_pulse: got aborted=%b done=%b want 1 0", aborted, done); end
    cmp++; if (busy !== 1'b0 || out !== 4'b1110) begin errs++; $display("FAIL abort_hold: got busy=%b out=%b want 0 1110", busy, out); end
    cif.abort = 1'b0;
    @(negedge clk);
    cmp++; if (aborted !== 1'b0 || cif.cmd_ready !== 1'b1) begin errs++; $display("FAIL abort_after: got aborted=%b ready=%b want 0 1", aborted, cif.cmd_ready); end
    issue(8, 1'b0);
    @(negedge clk);
    repeat (8) @(negedge clk);
    cmp++; if (out !== 4'b1110 || done !== 1'b1) begin errs++; $display("FAIL wrap8: got out=%b done=%b want 1110 1", out, done); end
    pos = 3;
  endtask

  task automatic test_async_reset();
    issue(10, 1'b0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    pos = (pos + 5) % N;
    cmp++; if (out !== code_of(pos)) begin errs++; $display("FAIL arst_pre: got %b want %b", out, code_of(pos)); end
    #2 reset = 1'b1;
    #1;
    cmp++; if (out !== 4'b0000 || busy !== 1'b0 || phase !== 3'd0) begin errs++; $display("FAIL arst_now: got out=%b busy=%b phase=%0d want 0000 0 0", out, busy, phase); end
    @(negedge clk);
    reset = 1'b0;
    pos = 0;
    @(negedge clk);
    cmp++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL arst_quiet: got done=%b aborted=%b busy=%b want 0 0 0", done, aborted, busy); end
    issue(2, 1'b0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    cmp++; if (out !== 4'b1100 || done !== 1'b1) begin errs++; $display("FAIL arst_resume: got out=%b done=%b want 1100 1", out, done); end
    pos = 2;
  endtask

  task automatic test_random();
    int   steps, ab_at, edges;
    logic dir;
    for (int c = 0; c < 30; c++) begin
      steps = int'($urandom_range(0, 19));
      dir   = 1'($urandom);
      ab_at = (steps > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, steps - 1)) : 0;
      edges = (ab_at != 0) ? ab_at : steps;
      issue(steps, dir);
      @(negedge clk);
      cmp++; if (busy !== (steps > 0) || done !== (steps == 0) || out !== code_of(pos)) begin
        errs++; $display("FAIL rnd_accept[%0d]: got busy=%b done=%b out=%b want %b %b %b", c, busy, done, out, steps > 0, steps == 0, code_of(pos)); end
      for (int k = 1; k <= edges; k++) begin
        if (k == ab_at) cif.abort = 1'b1;
        @(negedge clk);
        if (k != ab_at) pos = dir ? (pos + N - 1) % N : (pos + 1) % N;
        cmp++; if (out !== code_of(pos) || phase !== 3'(pos)) begin
          errs++; $display("FAIL rnd_code[%0d.%0d]: got out=%b phase=%0d want %b %0d", c, k, out, phase, code_of(pos), pos); end
        cmp++; if (busy !== (k < edges) || done !== (ab_at == 0 && k == steps) || aborted !== (k == ab_at)) begin
          errs++; $display("FAIL rnd_status[%0d.%0d]: got busy=%b done=%b aborted=%b want %b %b %b", c, k, busy, done, aborted, k < edges, ab_at == 0 && k == steps, k == ab_at); end
      end
      cif.abort = 1'b0;
      @(negedge clk);
      cmp++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || cif.cmd_ready !== 1'b1) begin
        errs++; $display("FAIL rnd_idle[%0d]: got done=%b aborted=%b busy=%b ready=%b want 0 0 0 1", c, done, aborted, busy, cif.cmd_ready); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cmp  = 0;
    errs = 0;
    pos  = 0;
    test_reset();
    test_fwd3();
    test_rev5();
    test_zero();
    test_abort_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
